sd_fifo_rx_filler_burst: RTL

- Parametrised successor to the SD RX FIFO filler, moving SD receive data into system memory.
- Buffers data words from the SD data path in an internal single-clock FIFO.
- Writes them to memory through a Wishbone master, starting at a programmed base address, for a programmed word count.
- Adds incrementing bursts, transfer length and done detection, bus error handling, overflow detection and a FIFO fill level.

---
 rtl/sd_fifo_rx_filler_burst.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/sd_fifo_rx_filler_burst.sv
// +--------------------------------------------------------------------------+
// | sd_fifo_rx_filler_burst: SD RX words -> FWFT FIFO -> Wishbone writes.    |
// | Optional macro SD_RX_FILLER_BURST_EN enables incrementing bursts. r1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module sd_fifo_rx_filler_burst #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int ADDR_INC   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [AW-1:0]                 adr,
  input  logic [15:0]                   len_words,
  input  logic                          wr,
  input  logic [DW-1:0]                 dat_i,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          done,
  output logic                          err,
  output logic [AW-1:0]                 m_wb_adr_o,
  output logic [DW-1:0]                 m_wb_dat_o,
  output logic [DW/8-1:0]               m_wb_sel_o,
  output logic                          m_wb_we_o,
  output logic                          m_wb_cyc_o,
  output logic                          m_wb_stb_o,
  output logic [2:0]                    m_wb_cti_o,
  output logic [1:0]                    m_wb_bte_o,
  input  logic                          m_wb_ack_i,
  input  logic                          m_wb_err_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

`ifdef SD_RX_FILLER_BURST_EN
  localparam int BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [15:0]   BL_REM    = 16'(BURST_LEN);
  localparam logic [LW-1:0] BL_LVL    = LW'(BURST_LEN);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BURST, S_SINGLE, S_DONE, S_ERROR} state_t;
  logic [BW-1:0] beat_q, beat_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SINGLE, S_DONE, S_ERROR} state_t;
`endif

  state_t        state_q, state_d;
  logic          en_q;
  logic [AW-1:0] adr_q, adr_d;
  logic [15:0]   rem_q, rem_d;
  logic          err_q, err_d;
  logic          full_q, full_d;
  logic [LW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];

  logic en_rise, push, beat_live, pop, bus_err;

  always_comb begin
    en_rise   = en & ~en_q;
    push      = en & wr & ~full_q;
`ifdef SD_RX_FILLER_BURST_EN
    beat_live = en & ((state_q == S_SINGLE) | (state_q == S_BURST));
`else
    beat_live = en & (state_q == S_SINGLE);
`endif
    bus_err   = beat_live & m_wb_err_i;
    pop       = beat_live & m_wb_ack_i & ~m_wb_err_i;
  end

  // FIFO bookkeeping; dropping en discards everything buffered.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (!en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + LW'(push) - LW'(pop);
      if (bus_err || (wr && full_q)) err_d = 1'b1;
    end
    full_d = (count_d == LW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
`ifdef SD_RX_FILLER_BURST_EN
    beat_d  = beat_q;
`endif
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (en_rise) begin
            adr_d   = adr;
            rem_d   = len_words;
            state_d = (len_words == 16'd0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
`ifdef SD_RX_FILLER_BURST_EN
          if (rem_q >= BL_REM && count_q >= BL_LVL) begin
            beat_d  = '0;
            state_d = S_BURST;
          end else if (rem_q < BL_REM && count_q != '0) begin
            state_d = S_SINGLE;
          end
`else
          if (count_q != '0) state_d = S_SINGLE;
`endif
        end
`ifdef SD_RX_FILLER_BURST_EN
        S_BURST: begin
          if (m_wb_err_i) begin
            state_d = S_ERROR;
          end else if (m_wb_ack_i) begin
            adr_d  = adr_q + AW'(ADDR_INC);
            rem_d  = rem_q - 16'd1;
            beat_d = beat_q + BW'(1);
            if (beat_q == BEAT_LAST) state_d = (rem_q == 16'd1) ? S_DONE : S_WAIT;
          end
        end
`endif
        S_SINGLE: begin
          if (m_wb_err_i) begin
            state_d = S_ERROR;
          end else if (m_wb_ack_i) begin
            adr_d   = adr_q + AW'(ADDR_INC);
            rem_d   = rem_q - 16'd1;
            state_d = (rem_q == 16'd1) ? S_DONE : S_WAIT;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      adr_q    <= '0;
      rem_q    <= '0;
      err_q    <= 1'b0;
      full_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef SD_RX_FILLER_BURST_EN
      beat_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      en_q     <= en;
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      err_q    <= err_d;
      full_q   <= full_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef SD_RX_FILLER_BURST_EN
      beat_q   <= beat_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dat_i;
  end

  always_comb begin
    m_wb_cyc_o = (state_q == S_SINGLE);
    m_wb_cti_o = 3'b000;
`ifdef SD_RX_FILLER_BURST_EN
    if (state_q == S_BURST) begin
      m_wb_cyc_o = 1'b1;
      m_wb_cti_o = (beat_q == BEAT_LAST) ? 3'b111 : 3'b010;
    end
`endif
    m_wb_stb_o = m_wb_cyc_o;
    m_wb_we_o  = m_wb_cyc_o;
    m_wb_adr_o = adr_q;
    m_wb_dat_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    m_wb_sel_o = '1;
    m_wb_bte_o = 2'b00;
    done       = (state_q == S_DONE);
    err        = err_q;
    level      = count_q;
    full       = full_q;
  end

endmodule

`default_nettype wire
